// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD up/down counter: segment glyphs and
// elaboration-time conversion of the decimal terminal count to packed BCD.
package bcd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Active-low {g,f,e,d,c,b,a}; anything that is not a decimal digit goes dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] pattern;
    case (bcd)
      4'd0:    pattern = ~7'h3F;
      4'd1:    pattern = ~7'h06;
      4'd2:    pattern = ~7'h5B;
      4'd3:    pattern = ~7'h4F;
      4'd4:    pattern = ~7'h66;
      4'd5:    pattern = ~7'h6D;
      4'd6:    pattern = ~7'h7D;
      4'd7:    pattern = ~7'h07;
      4'd8:    pattern = ~7'h7F;
      4'd9:    pattern = ~7'h67;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

  function automatic logic [31:0] to_bcd(input int value, input int digits);
    logic [31:0] result;
    int          rem;
    result = '0;
    rem    = value;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) begin
        result[4*i +: 4] = 4'(rem % 10);
        rem = rem / 10;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD chain: steps its digit when the decade below rolls over
// and passes its own carry (counting up) or borrow (counting down) upward.
import bcd_pkg::*;

module bcd_digit (
  input  logic [3:0] digit,
  input  logic       step,
  input  logic       up,
  input  logic       carry_in,
  output logic [3:0] next_digit,
  output logic       carry_out
);

  always_comb begin
    next_digit = digit;
    carry_out  = 1'b0;
    if (step && carry_in) begin
      if (up) begin
        if (digit >= DIGIT_MAX) begin
          next_digit = 4'd0;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          next_digit = DIGIT_MAX;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with programmable modulus, validated synchronous
// load, wrap/load-error pulses and per-digit active-low 7-segment outputs.
import bcd_pkg::*;

module bcd_updown_counter #(
  parameter int DIGITS   = 3,
  parameter int MAX      = 999,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int              W         = 4 * DIGITS;
  localparam logic [31:0]     MAX_BCD32 = to_bcd(MAX, DIGITS);
  localparam logic [W-1:0]    MAX_BCD   = MAX_BCD32[W-1:0];

  logic [W-1:0]    count_next;
  logic [DIGITS:0] carry;
  logic            at_max;
  logic            at_zero;
  logic            wrap_hit;
  logic            nibbles_ok;
  logic            load_ok;

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit      (q[4*g +: 4]),
      .step       (en),
      .up         (up),
      .carry_in   (carry[g]),
      .next_digit (count_next[4*g +: 4]),
      .carry_out  (carry[g+1])
    );
  end

  assign at_max  = (q == MAX_BCD);
  assign at_zero = (q == '0);
  assign tc      = en & (up ? at_max : at_zero);

  // Counting down, a borrow out of the top decade happens exactly when q is zero.
  assign wrap_hit = up ? at_max : carry[DIGITS];

  // With every nibble a valid decimal digit, packed BCD orders like the number.
  always_comb begin
    nibbles_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > DIGIT_MAX) nibbles_ok = 1'b0;
    end
  end

  assign load_ok = nibbles_ok && (d <= MAX_BCD);

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) q <= d;
        else         load_err <= 1'b1;
      end else if (en) begin
        if (wrap_hit) begin
          q    <= up ? '0 : MAX_BCD;
          wrap <= 1'b1;
        end else begin
          q <= count_next;
        end
      end
    end
  end

  // Scan from the top digit down; digits above the first nonzero one go dark.
  always_comb begin : blank_scan
    logic seen;
    seen = 1'b0;
    seg  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (q[4*i +: 4] != 4'd0) seen = 1'b1;
      if ((BLANK_LZ != 0) && !seen && (i != 0)) seg[7*i +: 7] = SEG_BLANK;
      else                                      seg[7*i +: 7] = seg_decode(q[4*i +: 4]);
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: four instances (999/3 digits with and without
// blanking, 59/2 digits, 1/1 digit) checked each cycle against a decimal model.
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, en_a, up_a, load_a;
  logic [11:0] d_a;
  logic        reset_b, en_b, up_b, load_b;
  logic [7:0]  d_b;

  logic [11:0] q_a, q_c;
  logic [7:0]  q_b;
  logic [3:0]  q_e;
  logic [20:0] seg_a, seg_c;
  logic [13:0] seg_b;
  logic [6:0]  seg_e;
  logic        tc_a, tc_c, tc_b, tc_e;
  logic        wrap_a, wrap_c, wrap_b, wrap_e;
  logic        load_err_a, load_err_c, load_err_b, load_err_e;

  bcd_updown_counter #(.DIGITS(3), .MAX(999), .BLANK_LZ(1)) dut_a (
    .clk(clk), .reset(reset_a), .en(en_a), .up(up_a), .load(load_a), .d(d_a),
    .q(q_a), .tc(tc_a), .wrap(wrap_a), .load_err(load_err_a), .seg(seg_a));

  bcd_updown_counter #(.DIGITS(3), .MAX(999), .BLANK_LZ(0)) dut_c (
    .clk(clk), .reset(reset_a), .en(en_a), .up(up_a), .load(load_a), .d(d_a),
    .q(q_c), .tc(tc_c), .wrap(wrap_c), .load_err(load_err_c), .seg(seg_c));

  bcd_updown_counter #(.DIGITS(2), .MAX(59), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .up(up_b), .load(load_b), .d(d_b),
    .q(q_b), .tc(tc_b), .wrap(wrap_b), .load_err(load_err_b), .seg(seg_b));

  bcd_updown_counter #(.DIGITS(1), .MAX(1), .BLANK_LZ(1)) dut_e (
    .clk(clk), .reset(reset_b), .en(en_b), .up(up_b), .load(load_b), .d(d_b[3:0]),
    .q(q_e), .tc(tc_e), .wrap(wrap_e), .load_err(load_err_e), .seg(seg_e));

  logic [31:0] q_o   [4];
  logic [55:0] seg_o [4];
  logic        tc_o  [4];
  logic        wrap_o[4];
  logic        le_o  [4];

  assign q_o[0] = 32'(q_a);  assign seg_o[0] = 56'(seg_a);
  assign q_o[1] = 32'(q_c);  assign seg_o[1] = 56'(seg_c);
  assign q_o[2] = 32'(q_b);  assign seg_o[2] = 56'(seg_b);
  assign q_o[3] = 32'(q_e);  assign seg_o[3] = 56'(seg_e);
  assign tc_o[0] = tc_a;  assign wrap_o[0] = wrap_a;  assign le_o[0] = load_err_a;
  assign tc_o[1] = tc_c;  assign wrap_o[1] = wrap_c;  assign le_o[1] = load_err_c;
  assign tc_o[2] = tc_b;  assign wrap_o[2] = wrap_b;  assign le_o[2] = load_err_b;
  assign tc_o[3] = tc_e;  assign wrap_o[3] = wrap_e;  assign le_o[3] = load_err_e;

  int dig_p[4] = '{3, 3, 2, 1};
  int max_p[4] = '{999, 999, 59, 1};
  int blk_p[4] = '{1, 0, 1, 1};

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  int mq [4] = '{0, 0, 0, 0};
  bit mw [4] = '{0, 0, 0, 0};
  bit mle[4] = '{0, 0, 0, 0};

  // Instances 0/1 share group A inputs, instances 2/3 share group B inputs.
  function automatic bit in_reset(int i); return (i < 2) ? reset_a : reset_b; endfunction
  function automatic bit in_en(int i);    return (i < 2) ? en_a    : en_b;    endfunction
  function automatic bit in_up(int i);    return (i < 2) ? up_a    : up_b;    endfunction
  function automatic bit in_load(int i);  return (i < 2) ? load_a  : load_b;  endfunction
  function automatic logic [31:0] in_d(int i);
    return (i < 2) ? 32'(d_a) : 32'(d_b);
  endfunction

  // Decimal value of a BCD word, or -1 when any nibble is not a digit.
  function automatic int dec_val(logic [31:0] dv, int digits);
    int v = 0;
    for (int k = digits - 1; k >= 0; k--) begin
      if (dv[4*k +: 4] > 4'd9) return -1;
      v = v * 10 + int'(dv[4*k +: 4]);
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_bcd(int v, int digits);
    logic [31:0] r = '0;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(int n);
    logic [6:0] lit;
    case (n)
      0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
      4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
      8: lit = 7'h7F;  default: lit = 7'h67;
    endcase
    return ~lit;
  endfunction

  function automatic logic [55:0] exp_seg(int v, int digits, int blank);
    logic [55:0] r = '0;
    int top = 0;
    int t = v;
    int k = 0;
    while (t > 0) begin
      top = k;
      t = t / 10;
      k++;
    end
    t = v;
    for (int j = 0; j < digits; j++) begin
      r[7*j +: 7] = (blank != 0 && j > top) ? 7'h7F : glyph(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit load_accepted(int i);
    int v = dec_val(in_d(i), dig_p[i]);
    return (v >= 0) && (v <= max_p[i]);
  endfunction

  function automatic int next_q(int i);
    if (in_reset(i)) return 0;
    if (in_load(i))  return load_accepted(i) ? dec_val(in_d(i), dig_p[i]) : mq[i];
    if (in_en(i)) begin
      if (in_up(i)) return (mq[i] == max_p[i]) ? 0 : mq[i] + 1;
      else          return (mq[i] == 0) ? max_p[i] : mq[i] - 1;
    end
    return mq[i];
  endfunction

  function automatic bit next_wrap(int i);
    return !in_reset(i) && !in_load(i) && in_en(i) &&
           (in_up(i) ? (mq[i] == max_p[i]) : (mq[i] == 0));
  endfunction

  function automatic bit next_le(int i);
    return !in_reset(i) && in_load(i) && !load_accepted(i);
  endfunction

  function automatic bit exp_tc(int i);
    return in_en(i) && (in_up(i) ? (mq[i] == max_p[i]) : (mq[i] == 0));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      mq[i]  <= next_q(i);
      mw[i]  <= next_wrap(i);
      mle[i] <= next_le(i);
    end
  end

  task automatic check_output(input string name, input int inst,
                              input logic [55:0] act, input logic [55:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d at %0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  // Full-state comparison of every instance, half a cycle after each edge.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 4; i++) begin
        check_output("q",        i, 56'(q_o[i]),   56'(exp_bcd(mq[i], dig_p[i])));
        check_output("tc",       i, 56'(tc_o[i]),  56'(exp_tc(i)));
        check_output("wrap",     i, 56'(wrap_o[i]), 56'(mw[i]));
        check_output("load_err", i, 56'(le_o[i]),  56'(mle[i]));
        check_output("seg",      i, seg_o[i],      exp_seg(mq[i], dig_p[i], blk_p[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int grp, input bit r, input bit l, input bit e,
                                input bit u, input logic [11:0] dv);
    if (grp == 0) begin
      reset_a = r; load_a = l; en_a = e; up_a = u; d_a = dv;
    end else begin
      reset_b = r; load_b = l; en_b = e; up_b = u; d_b = dv[7:0];
    end
  endtask

  initial begin
    logic [31:0] tmp;
    logic [11:0] dv;
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    checking = 1'b1;

    $display("[TB] reset and idle");
    check_output("rst_q_a",    0, 56'(q_a),        56'h000);
    check_output("rst_seg_a",  0, 56'(seg_a),      56'({7'h7F, 7'h7F, 7'h40}));
    check_output("rst_seg_c",  1, 56'(seg_c),      56'({7'h40, 7'h40, 7'h40}));
    check_output("rst_wrap_a", 0, 56'(wrap_a),     56'h0);
    check_output("rst_le_a",   0, 56'(load_err_a), 56'h0);

    $display("[TB] count up through 999");
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h998);
    tick();
    check_output("ld998_q", 0, 56'(q_a), 56'h998);
    apply_stimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    tick();
    check_output("q999",      0, 56'(q_a),    56'h999);
    check_output("tc999",     0, 56'(tc_a),   56'h1);
    check_output("wrap999",   0, 56'(wrap_a), 56'h0);
    tick();
    check_output("q000",      0, 56'(q_a),    56'h000);
    check_output("wrap000",   0, 56'(wrap_a), 56'h1);
    tick();
    check_output("q001",      0, 56'(q_a),    56'h001);
    check_output("wrap001",   0, 56'(wrap_a), 56'h0);

    $display("[TB] load rejection and priority");
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h1A5);
    tick();
    check_output("rej_q",   0, 56'(q_a),        56'h001);
    check_output("rej_le",  0, 56'(load_err_a), 56'h1);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h059);
    tick();
    check_output("ld059_q",  0, 56'(q_a),        56'h059);
    check_output("ld059_le", 0, 56'(load_err_a), 56'h0);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h500);
    tick();
    apply_stimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123);
    tick();
    check_output("ld_over_en", 0, 56'(q_a), 56'h123);
    apply_stimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h456);
    tick();
    check_output("rst_over_ld", 0, 56'(q_a), 56'h000);

    $display("[TB] blanking");
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h007);
    tick();
    check_output("blank_seg_a", 0, 56'(seg_a), 56'({7'h7F, 7'h7F, 7'h78}));
    check_output("blank_seg_c", 1, 56'(seg_c), 56'({7'h40, 7'h40, 7'h78}));
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    $display("[TB] modulus 59 down count and modulus 1");
    apply_stimulus(1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    tick();
    check_output("b_q59",    2, 56'(q_b),    56'h59);
    check_output("b_wrap59", 2, 56'(wrap_b), 56'h1);
    check_output("e_q1",     3, 56'(q_e),    56'h1);
    check_output("e_wrap1",  3, 56'(wrap_e), 56'h1);
    tick();
    check_output("b_q58",    2, 56'(q_b),    56'h58);
    check_output("b_wrap58", 2, 56'(wrap_b), 56'h0);
    check_output("e_wrap0",  3, 56'(wrap_e), 56'h0);
    tick();
    check_output("b_q57",    2, 56'(q_b),    56'h57);
    check_output("e_wrap2",  3, 56'(wrap_e), 56'h1);
    apply_stimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h060);
    tick();
    check_output("b_rej_q",  2, 56'(q_b),        56'h57);
    check_output("b_rej_le", 2, 56'(load_err_b), 56'h1);
    check_output("e_ld_q",   3, 56'(q_e),        56'h0);

    $display("[TB] randomized phase");
    for (int n = 0; n < 3000; n++) begin
      for (int grp = 0; grp < 2; grp++) begin
        if ($urandom_range(0, 1) == 0) begin
          dv = 12'($urandom);
        end else begin
          tmp = exp_bcd(int'($urandom_range(0, (grp == 0) ? 999 : 99)), 3);
          dv  = tmp[11:0];
        end
        apply_stimulus(grp, $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, dv);
      end
      tick();
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised N-digit BCD up/down counter with a programmable modulus, synchronous load with validity checking, a wrap pulse and per-digit active-low 7-segment outputs with optional leading-zero blanking. It replaces the fixed 4-bit loadable counter plus separate binary-to-BCD conversion path on the board top level. It drives HEX0..HEX(DIGITS-1) directly from switch/key inputs.

## Interface
Parameters:
- DIGITS, 3: number of BCD decades; legal range 1..8.
- MAX, 999: terminal count as a decimal integer; legal range 1 ≤ MAX ≤ 10^DIGITS − 1.
- BLANK_LZ, 1: 1 = blank leading-zero digits; 0 = show all digits.

Ports:
- clk  in  1  rising-edge clock, one clock domain.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; one step per clk while high.
- up  in  1  direction; 1 = increment, 0 = decrement.
- load  in  1  synchronous load request, active-high.
- d  in  4*DIGITS  BCD load value; digit 0 is in d[3:0].
- q  out  4*DIGITS  current BCD count; digit 0 is in q[3:0].
- tc  out  1  combinational terminal count: en & (up ? q==MAX : q==0).
- wrap  out  1  registered one-cycle pulse on the cycle after q wraps.
- load_err  out  1  registered one-cycle pulse on the cycle after a rejected load.
- seg  out  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit 0 is in seg[6:0].

## Operation
- Per-edge priority: reset > load > en > hold.
- reset: q=0, wrap=0, load_err=0.
- load: d is accepted only if every nibble ≤ 9 and value(d) ≤ MAX. On accept, q=d and load_err=0. On reject, q is unchanged and load_err=1. en is ignored on any cycle with load=1.
- Count up: if q==MAX then q=0 and wrap=1, else q=q+1 with decimal carry between decades.
- Count down: if q==0 then q=MAX and wrap=1, else q=q−1 with decimal borrow.
- Without a wrap event, wrap=0. Without a rejected load, load_err=0.
- q never holds a nibble above 9 and never exceeds MAX.
- seg is a combinational decode of q and shows digits 0–9 only.
- Blanking: with BLANK_LZ=1, every digit above the most significant nonzero digit outputs 7'h7F. Digit 0 is never blanked, so a value of 0 shows "0".
- Changing direction mid-count takes effect on the next enabled edge. There is no extra step.

## Timing
- q, wrap and load_err update on the rising clk edge at which the inputs are sampled. Latency is 1 cycle.
- tc and seg are combinational from q/en/up and are valid in the same cycle as q.
- wrap and load_err are high for exactly one cycle per event. Back-to-back events give back-to-back pulses; with MAX=1 and en held, wrap pulses every other cycle.
- A reset asserted mid-count clears state on that edge. Any pending pulse is dropped.
- Reset values: q=0, wrap=0, load_err=0. After reset, tc = en & ~up, and seg shows "0" on digit 0 (other digits blank if BLANK_LZ=1, otherwise "0").

## Structure
- Shared package bcd_pkg holds:
  - SEG_BLANK = 7'h7F
  - the function seg_decode(bcd) returning active-low 0–9 patterns: 0:~3F 1:~06 2:~5B 3:~4F 4:~66 5:~6D 6:~7D 7:~07 8:~7F 9:~67. Nibbles above 9 return SEG_BLANK.
  - the function to_bcd(int, digits) used to convert MAX into a BCD constant at elaboration.
- Sub-module bcd_digit: one decade. Inputs are the digit value, the step enable, up and the carry/borrow input. Outputs are next_digit and carry/borrow_out. It is instantiated DIGITS times in a generate loop.
- The top level holds the q register, the MAX/zero compare, load validation, the wrap/load_err registers and blanking.

## Test plan
- Reset then idle (DIGITS=3, MAX=999): q=000, wrap=0, seg digit0=~3F, digits 1–2 = 7F.
- Load 998, en=1, up=1 for 3 edges: q=999 → 000 → 001. wrap is high only in the cycle q=000. tc is high while q=999.
- DIGITS=2, MAX=59, from reset with en=1, up=0: q=59 on the first edge and wrap=1. Then 58, 57 with wrap=0.
- Load rejection: d=0x1A5 gives load_err=1 and q unchanged. On an instance with MAX=59, d=0x60 also gives load_err=1 and q unchanged. Loading d=0x059 gives q=059 and load_err=0.
- load=1 with en=1, d=0x123, from q=500: q=123 with no increment. reset=1 together with load=1: q=000.
- Blanking: q=007 gives seg digit2=7F, digit1=7F, digit0=~07. With BLANK_LZ=0, the same value gives ~3F, ~3F, ~07.
